mcbsp_frame_engine: RTL and testbench
=====================================

// Module: mcbsp_frame_engine
// PURPOSE
//  Next-gen McBSP slave link: one frame of WORDS_PER_FRAME x BITS_PER_WORD bits in and out per frame sync.
//  Runs entirely in the a_clk domain; mcbsp_clk, frame sync and rx are oversampled through synchronisers.
//  Adds double-buffered TX/RX, configurable bit order, a frame counter and resync/overrun error detection.
//  Sits between the AXIS word sources/sinks and the external McBSP master (DSP) pins.
// PARAMETERS
//  WORDS_PER_FRAME  8   words per frame (1..16)
//  BITS_PER_WORD    32  bits per word (1..32); N = WORDS_PER_FRAME*BITS_PER_WORD
//  SYNC_STAGES      2   synchroniser flops on mcbsp_clk/frame_start/data_rx (>=2)
//  CNT_WIDTH        16  width of frame_count
// PORTS
//  a_clk              in   1   system clock; must be >= 8x mcbsp_clk
//  a_resetn           in   1   asynchronous active-low reset
//  mcbsp_clk          in   1   McBSP bit clock from master
//  mcbsp_frame_start  in   1   frame sync from master
//  mcbsp_data_rx      in   1   serial data in
//  lsb_first          in   1   0: MSB of frame first, 1: bit 0 first; sampled at frame start
//  tx_data            in   N   parallel frame to send; word0 in top BITS_PER_WORD bits
//  tx_load            in   1   1-cycle strobe: copy tx_data into TX holding register
//  err_clear          in   1   clears sticky error flags
//  mcbsp_data_tx      out  1   serial data out
//  mcbsp_data_clkr    out  1   clock return (follows synced mcbsp_clk while ACTIVE)
//  mcbsp_data_frm     out  1   high while ACTIVE
//  trigger            out  1   1-cycle pulse at accepted frame start
//  rx_data            out  N   last complete received frame
//  rx_valid           out  1   1-cycle pulse when rx_data updates
//  frame_count        out  CNT_WIDTH  completed frames, wraps modulo 2^CNT_WIDTH
//  err_resync         out  1   sticky: frame sync seen mid-frame
//  err_overrun        out  1   sticky: frame started with no tx_load since previous start
// BEHAVIOUR
//  Reset: all outputs 0, rx_data 0, frame_count 0, TX holding reg 0, state IDLE. Async assert, sync release.
//  Input path: each pin through SYNC_STAGES flops; edge detect on synced clk -> rise/fall 1-cycle strobes.
//  States: IDLE, ACTIVE. bit_cnt counts N-1 down to 0.
//  IDLE: on fall with synced fs=1 -> ACTIVE; shift_tx <= TX holding (bit-reversed if lsb_first=1);
//   bit_cnt <= N-1; trigger=1 next cycle; err_overrun set if no tx_load since previous start.
//  ACTIVE rise: mcbsp_data_tx <= shift_tx[N-1], shift_tx <<= 1; mcbsp_data_clkr <= 1.
//  ACTIVE fall (fs=0): shift_rx <= {shift_rx[N-2:0], rx}; mcbsp_data_clkr <= 0;
//   bit_cnt==0 -> IDLE, rx_data <= shift_rx incl. this bit (bit-reversed if lsb_first), rx_valid pulse,
//   frame_count++ ; else bit_cnt--.
//  First data bit: driven on rise after sync fall, sampled on the following fall (one bit-clock after sync).
//  Mid-frame sync (fall, fs=1, ACTIVE): set err_resync, discard partial RX (no rx_valid, no count),
//   restart frame exactly as from IDLE (trigger pulses again).
//  fs=1 on the final-bit fall: final bit completes first (rx_valid, count), then new frame starts same cycle.
//  tx_load same cycle as frame start: old holding value used for this frame; new value for next.
//  err_clear same cycle as new error: error wins (flag stays 1).
//  mcbsp_data_tx holds last bit in IDLE; mcbsp_data_clkr 0 in IDLE.
//  Pin-to-response latency: SYNC_STAGES+1 a_clk cycles.
// TESTING
//  W=2,B=8, tx_load 16'hA55A, lsb_first=0, rx=16'h3C96 -> tx stream A55A MSB first, rx_data=16'h3C96, rx_valid x1, count=1.
//  Same with lsb_first=1, rx bits sent LSB first -> tx stream 0x5AA5 bit-reversed order, rx_data=16'h3C96.
//  Sync re-asserted after 5 bits -> err_resync=1, no rx_valid, trigger twice, next full frame received correctly.
//  Two frames, tx_load only before first -> err_overrun=1 at second start, second frame re-sends A55A; err_clear -> 0.
//  a_resetn low after 7 bits -> all outputs 0 immediately; next sync gives clean full frame, count=1.
//  2^CNT_WIDTH frames with CNT_WIDTH=4 (16 frames) -> frame_count wraps to 0, no error flags.

Source files
------------

// File: rtl/mcbsp_frame_engine.sv
// McBSP slave frame engine: oversamples the master's bit clock, frame sync and data in the
// a_clk domain. Shifts one double-buffered N-bit frame out and one in per frame sync.
module mcbsp_frame_engine #(
   parameter int WORDS_PER_FRAME = 8,
   parameter int BITS_PER_WORD   = 32,
   parameter int SYNC_STAGES     = 2,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                                      a_clk,
   input  logic                                      a_resetn,
   input  logic                                      mcbsp_clk,
   input  logic                                      mcbsp_frame_start,
   input  logic                                      mcbsp_data_rx,
   input  logic                                      lsb_first,
   input  logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0]  tx_data,
   input  logic                                      tx_load,
   input  logic                                      err_clear,
   output logic                                      mcbsp_data_tx,
   output logic                                      mcbsp_data_clkr,
   output logic                                      mcbsp_data_frm,
   output logic                                      trigger,
   output logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0]  rx_data,
   output logic                                      rx_valid,
   output logic [CNT_WIDTH-1:0]                      frame_count,
   output logic                                      err_resync,
   output logic                                      err_overrun
);

   localparam int N   = WORDS_PER_FRAME * BITS_PER_WORD;
   localparam int BCW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state, state_nxt;
   logic [1:0]             rst_sync;
   logic                   rst_n;
   logic [SYNC_STAGES-1:0] clk_sync, fs_sync, rx_sync;
   logic                   clk_s, fs_s, rx_s, clk_prev;
   logic                   rise, fall, active, start, last_bit, resync;
   logic [BCW-1:0]         bit_cnt;
   logic [N-1:0]           tx_hold, shift_tx, shift_rx, rx_next;
   logic                   lsb_q, loaded;

   function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = v[N-1-i];
      return r;
   endfunction

   // Reset asserts asynchronously but releases on a_clk so every flop leaves reset together.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) rst_sync <= '0;
      else           rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge a_clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= '0;
         fs_sync  <= '0;
         rx_sync  <= '0;
         clk_prev <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], mcbsp_clk};
         fs_sync  <= {fs_sync[SYNC_STAGES-2:0], mcbsp_frame_start};
         rx_sync  <= {rx_sync[SYNC_STAGES-2:0], mcbsp_data_rx};
         clk_prev <= clk_s;
      end
   end

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign fs_s     = fs_sync[SYNC_STAGES-1];
   assign rx_s     = rx_sync[SYNC_STAGES-1];
   assign rise     = clk_s & ~clk_prev;
   assign fall     = ~clk_s & clk_prev;
   assign active   = (state == ACTIVE);
   assign start    = fall & fs_s;
   assign last_bit = active & fall & (bit_cnt == '0);
   assign resync   = active & fall & fs_s & (bit_cnt != '0);
   assign rx_next  = N'({shift_rx, rx_s});

   assign mcbsp_data_frm = active;

   always_ff @(posedge a_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A sync on the final-bit fall lets the frame complete and then restarts, so start wins.
   always_comb begin
      state_nxt = state;
      if (start)         state_nxt = ACTIVE;
      else if (last_bit) state_nxt = IDLE;
   end

   always_ff @(posedge a_clk or negedge rst_n) begin
      if (!rst_n) begin
         mcbsp_data_tx   <= 1'b0;
         mcbsp_data_clkr <= 1'b0;
         trigger         <= 1'b0;
         rx_valid        <= 1'b0;
         rx_data         <= '0;
         frame_count     <= '0;
         err_resync      <= 1'b0;
         err_overrun     <= 1'b0;
         bit_cnt         <= '0;
         tx_hold         <= '0;
         shift_tx        <= '0;
         shift_rx        <= '0;
         lsb_q           <= 1'b0;
         loaded          <= 1'b0;
      end else begin
         trigger  <= start;
         rx_valid <= last_bit;
         if (tx_load) tx_hold <= tx_data;
         if (active && rise) begin
            mcbsp_data_tx   <= shift_tx[N-1];
            shift_tx        <= shift_tx << 1;
            mcbsp_data_clkr <= 1'b1;
         end
         if (fall) mcbsp_data_clkr <= 1'b0;
         if (active && fall) begin
            shift_rx <= rx_next;
            if (bit_cnt != '0) bit_cnt <= bit_cnt - BCW'(1);
         end
         if (last_bit) begin
            rx_data     <= lsb_q ? bit_rev(rx_next) : rx_next;
            frame_count <= frame_count + CNT_WIDTH'(1);
         end
         // A load coinciding with the start still counts toward the next frame.
         if (start) begin
            shift_tx <= lsb_first ? bit_rev(tx_hold) : tx_hold;
            bit_cnt  <= BCW'(N - 1);
            lsb_q    <= lsb_first;
            loaded   <= 1'b0;
         end
         if (tx_load) loaded <= 1'b1;
         if (err_clear) begin
            err_resync  <= 1'b0;
            err_overrun <= 1'b0;
         end
         if (resync)            err_resync  <= 1'b1;
         if (start && !loaded)  err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mcbsp_frame_engine.sv
// Bench for mcbsp_frame_engine: the bench plays the McBSP master, a monitor logs every rx_valid,
// and expected frames queued at stimulus time are compared against that log.
module tb_mcbsp_frame_engine;

   localparam int W  = 2;
   localparam int B  = 8;
   localparam int N  = W * B;
   localparam int SS = 2;
   localparam int CW = 4;

   logic          a_clk = 1'b0;
   logic          a_resetn = 1'b0;
   logic          mcbsp_clk = 1'b0;
   logic          mcbsp_frame_start = 1'b0;
   logic          mcbsp_data_rx = 1'b0;
   logic          lsb_first = 1'b0;
   logic [N-1:0]  tx_data = '0;
   logic          tx_load = 1'b0;
   logic          err_clear = 1'b0;
   logic          mcbsp_data_tx, mcbsp_data_clkr, mcbsp_data_frm, trigger, rx_valid;
   logic [N-1:0]  rx_data;
   logic [CW-1:0] frame_count;
   logic          err_resync, err_overrun;

   mcbsp_frame_engine #(
      .WORDS_PER_FRAME(W), .BITS_PER_WORD(B), .SYNC_STAGES(SS), .CNT_WIDTH(CW)
   ) dut (
      .a_clk(a_clk), .a_resetn(a_resetn), .mcbsp_clk(mcbsp_clk),
      .mcbsp_frame_start(mcbsp_frame_start), .mcbsp_data_rx(mcbsp_data_rx),
      .lsb_first(lsb_first), .tx_data(tx_data), .tx_load(tx_load), .err_clear(err_clear),
      .mcbsp_data_tx(mcbsp_data_tx), .mcbsp_data_clkr(mcbsp_data_clkr),
      .mcbsp_data_frm(mcbsp_data_frm), .trigger(trigger), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_count(frame_count), .err_resync(err_resync),
      .err_overrun(err_overrun)
   );

   always #5 a_clk = ~a_clk;

   typedef struct {
      logic         lsb;
      logic [15:0]  tx;
      logic [15:0]  rx_wire;
      logic [15:0]  exp_stream;
      logic [15:0]  exp_rx;
   } vec_t;

   typedef struct {
      logic [15:0]   rx;
      logic [CW-1:0] cnt;
   } frm_t;

   vec_t    vecs[5];
   frm_t    exp_q[$];
   frm_t    got_q[$];
   int      exp_idx = 0;
   int      got_idx = 0;
   int      tests = 0;
   int      fails = 0;
   int      trig_cnt = 0;
   logic [CW-1:0] exp_count = '0;

   always @(negedge a_clk) begin
      if (rx_valid) got_q.push_back('{rx: rx_data, cnt: frame_count});
      if (trigger) trig_cnt = trig_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic pulse_load(input logic [15:0] v);
      tx_data = v;
      tx_load = 1'b1;
      @(negedge a_clk);
      tx_load = 1'b0;
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge a_clk);
      err_clear = 1'b0;
   endtask

   // One bit clock: rise with fs/rx changing, tx sampled late in the high half, then fall.
   task automatic bit_cycle(input logic fs_v, input logic rx_v,
                            output logic tx_s, output logic frm_s, output logic clkr_s);
      mcbsp_clk = 1'b1;
      mcbsp_frame_start = fs_v;
      mcbsp_data_rx = rx_v;
      repeat (8) @(negedge a_clk);
      tx_s   = mcbsp_data_tx;
      frm_s  = mcbsp_data_frm;
      clkr_s = mcbsp_data_clkr;
      mcbsp_clk = 1'b0;
      repeat (8) @(negedge a_clk);
   endtask

   task automatic run_frame(input logic [15:0] rx_wire, input logic do_start, input logic fs_last,
                            input int nbits, input int load_at, input logic [15:0] load_val,
                            output logic [15:0] stream, output logic frm_all, output logic clkr_all);
      logic t, f, c;
      stream = '0;
      frm_all = 1'b1;
      clkr_all = 1'b1;
      if (do_start) bit_cycle(1'b1, 1'b0, t, f, c);
      for (int i = 0; i < nbits; i++) begin
         if (i == load_at) pulse_load(load_val);
         bit_cycle(fs_last && (i == nbits - 1), rx_wire[N-1-i], t, f, c);
         stream[N-1-i] = t;
         frm_all  = frm_all & f;
         clkr_all = clkr_all & c;
      end
   endtask

   task automatic expect_frame(input logic [15:0] rx);
      exp_count = exp_count + 1'b1;
      exp_q.push_back('{rx: rx, cnt: exp_count});
   endtask

   task automatic drain(input string tag);
      while (exp_idx < exp_q.size()) begin
         if (got_idx < got_q.size()) begin
            check($sformatf("%s rx_data", tag), 32'(got_q[got_idx].rx), 32'(exp_q[exp_idx].rx));
            check($sformatf("%s frame_count", tag), 32'(got_q[got_idx].cnt), 32'(exp_q[exp_idx].cnt));
            got_idx++;
         end else begin
            check($sformatf("%s rx_valid missing", tag), 32'(0), 32'(1));
         end
         exp_idx++;
      end
      check($sformatf("%s extra rx_valid", tag), 32'(got_q.size() - got_idx), 32'(0));
      got_idx = got_q.size();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " data_tx"},     32'(mcbsp_data_tx),   32'(0));
      check({tag, " clkr"},        32'(mcbsp_data_clkr), 32'(0));
      check({tag, " frm"},         32'(mcbsp_data_frm),  32'(0));
      check({tag, " trigger"},     32'(trigger),         32'(0));
      check({tag, " rx_valid"},    32'(rx_valid),        32'(0));
      check({tag, " rx_data"},     32'(rx_data),         32'(0));
      check({tag, " frame_count"}, 32'(frame_count),     32'(0));
      check({tag, " err_resync"},  32'(err_resync),      32'(0));
      check({tag, " err_overrun"}, 32'(err_overrun),     32'(0));
   endtask

   task automatic do_reset();
      a_resetn = 1'b0;
      mcbsp_clk = 1'b0;
      mcbsp_frame_start = 1'b0;
      mcbsp_data_rx = 1'b0;
      repeat (3) @(negedge a_clk);
      a_resetn = 1'b1;
      repeat (4) @(negedge a_clk);
      exp_count = '0;
   endtask

   initial begin
      logic [15:0] s1, s2;
      logic        frm1, clkr1, frm2, clkr2;
      int          t0;

      vecs[0] = '{lsb: 1'b0, tx: 16'hA55A, rx_wire: 16'h3C96, exp_stream: 16'hA55A, exp_rx: 16'h3C96};
      vecs[1] = '{lsb: 1'b1, tx: 16'hA55A, rx_wire: 16'h693C, exp_stream: 16'h5AA5, exp_rx: 16'h3C96};
      vecs[2] = '{lsb: 1'b0, tx: 16'h0001, rx_wire: 16'h8001, exp_stream: 16'h0001, exp_rx: 16'h8001};
      vecs[3] = '{lsb: 1'b1, tx: 16'h0001, rx_wire: 16'h0001, exp_stream: 16'h8000, exp_rx: 16'h8000};
      vecs[4] = '{lsb: 1'b0, tx: 16'hFFFF, rx_wire: 16'h0000, exp_stream: 16'hFFFF, exp_rx: 16'h0000};

      repeat (3) @(negedge a_clk);
      check_all_zero("reset");
      a_resetn = 1'b1;
      repeat (4) @(negedge a_clk);

      for (int v = 0; v < 5; v++) begin
         lsb_first = vecs[v].lsb;
         pulse_load(vecs[v].tx);
         t0 = trig_cnt;
         expect_frame(vecs[v].exp_rx);
         run_frame(vecs[v].rx_wire, 1'b1, 1'b0, N, -1, 16'h0, s1, frm1, clkr1);
         repeat (4) @(negedge a_clk);
         check($sformatf("vec%0d tx stream", v), 32'(s1), 32'(vecs[v].exp_stream));
         check($sformatf("vec%0d frm active", v), 32'(frm1), 32'(1));
         check($sformatf("vec%0d clkr active", v), 32'(clkr1), 32'(1));
         check($sformatf("vec%0d triggers", v), 32'(trig_cnt - t0), 32'(1));
         check($sformatf("vec%0d frm idle", v), 32'(mcbsp_data_frm), 32'(0));
         check($sformatf("vec%0d clkr idle", v), 32'(mcbsp_data_clkr), 32'(0));
         check($sformatf("vec%0d errors", v), 32'({err_resync, err_overrun}), 32'(0));
         drain($sformatf("vec%0d", v));
      end
      lsb_first = 1'b0;

      // Sync re-asserted after 5 bits; a reload mid-frame keeps the restart free of overrun.
      pulse_load(16'hA55A);
      t0 = trig_cnt;
      run_frame(16'hFFFF, 1'b1, 1'b0, 5, 3, 16'h1234, s1, frm1, clkr1);
      expect_frame(16'h3C96);
      run_frame(16'h3C96, 1'b1, 1'b0, N, -1, 16'h0, s2, frm2, clkr2);
      repeat (4) @(negedge a_clk);
      check("resync err_resync", 32'(err_resync), 32'(1));
      check("resync err_overrun", 32'(err_overrun), 32'(0));
      check("resync triggers", 32'(trig_cnt - t0), 32'(2));
      check("resync tx stream", 32'(s2), 32'(16'h1234));
      drain("resync");
      pulse_clear();
      check("resync cleared", 32'(err_resync), 32'(0));

      // Sync on the final-bit fall: frame completes, next starts with no gap.
      pulse_load(16'h0F0F);
      t0 = trig_cnt;
      expect_frame(16'hC3A5);
      run_frame(16'hC3A5, 1'b1, 1'b1, N, 2, 16'hF0F0, s1, frm1, clkr1);
      expect_frame(16'h5A3C);
      run_frame(16'h5A3C, 1'b0, 1'b0, N, -1, 16'h0, s2, frm2, clkr2);
      repeat (4) @(negedge a_clk);
      check("b2b stream1", 32'(s1), 32'(16'h0F0F));
      check("b2b stream2", 32'(s2), 32'(16'hF0F0));
      check("b2b triggers", 32'(trig_cnt - t0), 32'(2));
      check("b2b errors", 32'({err_resync, err_overrun}), 32'(0));
      drain("b2b");

      // Overrun: second frame without a fresh tx_load re-sends the held word.
      pulse_load(16'hA55A);
      expect_frame(16'h1111);
      run_frame(16'h1111, 1'b1, 1'b0, N, -1, 16'h0, s1, frm1, clkr1);
      repeat (4) @(negedge a_clk);
      check("ovr first err_overrun", 32'(err_overrun), 32'(0));
      expect_frame(16'h2222);
      run_frame(16'h2222, 1'b1, 1'b0, N, -1, 16'h0, s2, frm2, clkr2);
      repeat (4) @(negedge a_clk);
      check("ovr second err_overrun", 32'(err_overrun), 32'(1));
      check("ovr second stream", 32'(s2), 32'(16'hA55A));
      drain("ovr");
      pulse_clear();
      check("ovr cleared", 32'(err_overrun), 32'(0));

      // Reset in the middle of a frame.
      pulse_load(16'h1111);
      run_frame(16'hFFFF, 1'b1, 1'b0, 7, -1, 16'h0, s1, frm1, clkr1);
      check("midreset frm before", 32'(mcbsp_data_frm), 32'(1));
      a_resetn = 1'b0;
      #1;
      check_all_zero("midreset");
      @(negedge a_clk);
      mcbsp_clk = 1'b0;
      mcbsp_frame_start = 1'b0;
      mcbsp_data_rx = 1'b0;
      @(negedge a_clk);
      a_resetn = 1'b1;
      repeat (4) @(negedge a_clk);
      exp_count = '0;
      pulse_load(16'h2468);
      expect_frame(16'hBEEF);
      run_frame(16'hBEEF, 1'b1, 1'b0, N, -1, 16'h0, s1, frm1, clkr1);
      repeat (4) @(negedge a_clk);
      check("postreset stream", 32'(s1), 32'(16'h2468));
      check("postreset errors", 32'({err_resync, err_overrun}), 32'(0));
      drain("postreset");

      // 2^CW frames wrap the counter back to zero.
      do_reset();
      for (int k = 0; k < (1 << CW); k++) begin
         pulse_load(16'(k * 16'h1111));
         expect_frame(16'(k) ^ 16'hA5A5);
         run_frame(16'(k) ^ 16'hA5A5, 1'b1, 1'b0, N, -1, 16'h0, s1, frm1, clkr1);
      end
      repeat (4) @(negedge a_clk);
      check("wrap frame_count", 32'(frame_count), 32'(0));
      check("wrap errors", 32'({err_resync, err_overrun}), 32'(0));
      drain("wrap");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
